// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a one-byte holding register so the upstream buffer
// can hand over the next byte while the current frame is still shifting out.
module uart_tx_serializer #(
   parameter int CLOCKS_PER_BIT = 13,
   parameter int STOP_BITS      = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       uart_tx,
   output logic       busy
);

   localparam int                CNT_W     = $clog2(CLOCKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
   logic [2:0]       bit_idx, bit_idx_nx;
   logic             hold_full, hold_full_nx;
   logic             rdy_en;
   logic [7:0]       hold;
   logic [7:0]       shifter, shifter_nx;
   logic             uart_tx_nx;
   logic             baud_tick;
   logic             accept;
   logic             load;

   assign baud_tick     = (baud_cnt == BAUD_LAST);
   // rdy_en keeps ready low until the first edge after reset release
   assign data_in_ready = rdy_en && !hold_full;
   assign accept        = data_in_valid && data_in_ready;
   assign busy          = (state != IDLE) || hold_full;

   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_tick ? '0 : baud_cnt + 1'b1;
      bit_idx_nx  = bit_idx;
      shifter_nx  = shifter;
      load        = 1'b0;
      uart_tx_nx  = 1'b1;

      case (state)
         IDLE: begin
            baud_cnt_nx = '0;
            if (hold_full) begin
               load     = 1'b1;
               state_nx = START;
            end
         end
         START: begin
            if (baud_tick) begin
               state_nx   = DATA;
               bit_idx_nx = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shifter_nx = {1'b0, shifter[7:1]};
               if (bit_idx == 3'd7) begin
                  state_nx   = STOP;
                  bit_idx_nx = '0;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (bit_idx == STOP_LAST) begin
                  bit_idx_nx = '0;
                  // chain straight into the next start bit when a byte is waiting
                  if (hold_full) begin
                     load     = 1'b1;
                     state_nx = START;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      if (load) shifter_nx = hold;
      hold_full_nx = load ? 1'b0 : (accept ? 1'b1 : hold_full);

      // line value is registered from the next state so it changes on the same edge
      case (state_nx)
         START:   uart_tx_nx = 1'b0;
         DATA:    uart_tx_nx = shifter_nx[0];
         default: uart_tx_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         hold_full <= 1'b0;
         rdy_en    <= 1'b0;
         uart_tx   <= 1'b1;
      end else begin
         state     <= state_nx;
         baud_cnt  <= baud_cnt_nx;
         bit_idx   <= bit_idx_nx;
         hold_full <= hold_full_nx;
         rdy_en    <= 1'b1;
         uart_tx   <= uart_tx_nx;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) hold <= data_in;
      shifter <= shifter_nx;
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed frame tables, handshake corner cases,
// async reset mid-frame, random traffic through a reference receiver, 2-stop-bit variant.
module tb_uart_tx_serializer;

   localparam int CPB   = 13;
   localparam int CPB_B = 104;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;
   logic       uart_tx;
   logic       busy;
   logic [7:0] b_data;
   logic       b_valid;
   logic       b_ready;
   logic       b_tx;
   logic       b_busy;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   logic [7:0] sb[$];

   logic cap_a  [0:1299];
   logic cap_ra [0:1299];
   logic cap_ba [0:1299];
   logic cap_b  [0:1299];
   logic cap_bb [0:1299];

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
   } vec_t;
   vec_t vecs [0:5];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   uart_tx_serializer #(.CLOCKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .uart_tx(uart_tx), .busy(busy));

   uart_tx_serializer #(.CLOCKS_PER_BIT(CPB_B), .STOP_BITS(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .data_in(b_data), .data_in_valid(b_valid),
      .data_in_ready(b_ready), .uart_tx(b_tx), .busy(b_busy));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input int budget, output int acc);
      data_in       = d;
      data_in_valid = 1'b1;
      acc           = -1;
      for (int i = 0; i < budget; i++) begin
         if (data_in_ready) begin
            tick();
            acc = cyc;
            sb.push_back(d);
            break;
         end
         tick();
      end
      data_in_valid = 1'b0;
      check("send_accepted", (acc >= 0), 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) break;
         tick();
      end
      check("drain_idle", busy, 1'b0);
   endtask

   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         cap_a[k]  = uart_tx;
         cap_ra[k] = data_in_ready;
         cap_ba[k] = busy;
         cap_b[k]  = b_tx;
         cap_bb[k] = b_busy;
      end
   endtask

   // every bit must hold its expected level for all of its clocks
   task automatic check_bits(input string name, input int cpb, input int nbits,
                             input logic [31:0] pat, input bit useb);
      logic got;
      logic s;
      for (int b = 0; b < nbits; b++) begin
         got = pat[b];
         for (int j = 0; j < cpb; j++) begin
            s = useb ? cap_b[b*cpb+j] : cap_a[b*cpb+j];
            if (s !== pat[b]) got = s;
         end
         check($sformatf("%s_bit%0d", name, b), got, pat[b]);
      end
   endtask

   // reference receiver: samples mid-bit, pops the scoreboard at the stop bit
   task automatic rx_monitor();
      int st;
      int cnt;
      int k;
      logic [7:0] sh;
      logic start_bit;
      logic [7:0] exp;
      st = 0; cnt = 0; sh = '0; start_bit = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            st = 0;
         end else if (st == 0) begin
            if (!uart_tx) begin
               st  = 1;
               cnt = 0;
            end
         end else begin
            cnt++;
            if ((cnt - CPB/2) % CPB == 0) begin
               k = (cnt - CPB/2) / CPB;
               if (k == 0) start_bit = uart_tx;
               else if (k <= 8) sh[k-1] = uart_tx;
               else begin
                  check("rx_start", start_bit, 1'b0);
                  check("rx_stop", uart_tx, 1'b1);
                  check("rx_queue_nonempty", (sb.size() != 0), 1'b1);
                  if (sb.size() != 0) begin
                     exp = sb.pop_front();
                     check("rx_byte", sh, exp);
                  end
                  st = 0;
               end
            end
         end
      end
   endtask

   int     n0, n1, acc2, acc3, nb, gap, phase;
   logic   pre, any;
   integer seed = 12345;

   initial begin
      vecs[0] = '{8'hA5, 10'b1_10100101_0};
      vecs[1] = '{8'h00, 10'b1_00000000_0};
      vecs[2] = '{8'hFF, 10'b1_11111111_0};
      vecs[3] = '{8'h01, 10'b1_00000001_0};
      vecs[4] = '{8'h80, 10'b1_10000000_0};
      vecs[5] = '{8'h3C, 10'b1_00111100_0};

      reset_n = 1'b0; data_in = '0; data_in_valid = 1'b0; b_data = '0; b_valid = 1'b0;
      fork
         rx_monitor();
      join_none

      #23;
      check("rst_tx", uart_tx, 1'b1);
      check("rst_ready", data_in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_b_tx", b_tx, 1'b1);
      check("rst_b_ready", b_ready, 1'b0);
      check("rst_b_busy", b_busy, 1'b0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      check("ready_before_edge", data_in_ready, 1'b0);
      tick();
      check("ready_after_edge", data_in_ready, 1'b1);
      check("b_ready_after_edge", b_ready, 1'b1);

      // single frames from the vector table
      for (int v = 0; v < 6; v++) begin
         send_byte(vecs[v].data, 20, n0);
         check("tx_high_at_accept", uart_tx, 1'b1);
         check("busy_at_accept", busy, 1'b1);
         capture(10*CPB);
         check_bits($sformatf("vec%0d", v), CPB, 10, {22'd0, vecs[v].line}, 1'b0);
         check("busy_last_stop_cycle", cap_ba[10*CPB-1], 1'b1);
         tick();
         check("busy_after_frame", busy, 1'b0);
         check("tx_after_frame", uart_tx, 1'b1);
         check("ready_after_frame", data_in_ready, 1'b1);
      end

      // back-to-back 0x00 then 0xFF with valid held high
      send_byte(8'h00, 20, n0);
      data_in = 8'hFF; data_in_valid = 1'b1; acc2 = -1;
      for (int k = 0; k < 260; k++) begin
         pre = data_in_valid && data_in_ready;
         tick();
         if (pre) begin
            acc2 = cyc;
            sb.push_back(8'hFF);
            data_in_valid = 1'b0;
         end
         cap_a[k]  = uart_tx;
         cap_ra[k] = data_in_ready;
      end
      data_in_valid = 1'b0;
      check("b2b_second_accept", acc2 - n0, 2);
      check_bits("b2b", CPB, 20, {12'd0, 10'b1_11111111_0, 10'b1_00000000_0}, 1'b0);
      any = 1'b0;
      for (int k = 1; k < 130; k++) if (cap_ra[k]) any = 1'b1;
      check("b2b_ready_low", any, 1'b0);
      check("b2b_ready_after_stop", cap_ra[130], 1'b1);
      wait_idle(300);

      // valid held while hold_full; data_in changes mid-wait
      send_byte(8'h5A, 20, n0);
      data_in = 8'h33; data_in_valid = 1'b1; phase = 0; acc2 = -1; acc3 = -1;
      for (int k = 1; k <= 200 && phase < 2; k++) begin
         pre = data_in_valid && data_in_ready;
         tick();
         if (pre) begin
            if (phase == 0) begin
               acc2 = cyc;
               sb.push_back(8'h33);
               data_in = 8'h11;
            end else begin
               acc3 = cyc;
               sb.push_back(8'h22);
               data_in_valid = 1'b0;
            end
            phase++;
         end
         if (cyc - n0 == 50) data_in = 8'h22;
      end
      data_in_valid = 1'b0;
      check("full_second_accept", acc2 - n0, 2);
      check("full_third_accept", acc3 - n0, 132);
      wait_idle(600);
      repeat (20) tick();

      // async reset mid-frame with a byte held
      send_byte(8'hC3, 20, n0);
      send_byte(8'h77, 20, n1);
      while (cyc < n0 + 61) tick();
      check("tx_mid_frame", uart_tx, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_tx", uart_tx, 1'b1);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_ready", data_in_ready, 1'b0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      sb.delete();
      check("rel_ready_before_edge", data_in_ready, 1'b0);
      tick();
      check("rel_ready_after_edge", data_in_ready, 1'b1);
      check("rel_busy", busy, 1'b0);
      capture(300);
      any = 1'b0;
      for (int k = 0; k < 300; k++) if (!cap_a[k] || cap_ba[k]) any = 1'b1;
      check("no_replay_after_reset", any, 1'b0);

      // random traffic with exponential gaps
      for (int i = 0; i < 256; i++) begin
         gap = $dist_exponential(seed, 6);
         if (gap > 60) gap = 60;
         repeat (gap) tick();
         send_byte(8'($urandom), 400, n1);
      end
      wait_idle(600);
      repeat (20) tick();
      check("rx_all_decoded", sb.size(), 0);

      // two stop bits at 104 clocks per bit
      b_data = 8'h80; b_valid = 1'b1; nb = -1;
      for (int i = 0; i < 10; i++) begin
         pre = b_valid && b_ready;
         tick();
         if (pre) begin
            nb = cyc;
            b_valid = 1'b0;
            break;
         end
      end
      b_valid = 1'b0;
      check("b_accepted", (nb >= 0), 1'b1);
      check("b_tx_at_accept", b_tx, 1'b1);
      capture(11*CPB_B);
      check_bits("b", CPB_B, 11, {21'd0, 11'b11_10000000_0}, 1'b1);
      check("b_busy_last_cycle", cap_bb[11*CPB_B-1], 1'b1);
      tick();
      check("b_busy_after_frame", b_busy, 1'b0);
      check("b_tx_after_frame", b_tx, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
